// File: rtl/patp_pkg.sv
// patp_pkg: shared constants for the PATP accumulator core control path.
//   - opcode field values (3-bit IR opcode)
//   - ALU operation selects (2-bit)
//   - control FSM state encodings (3-bit, exported on state_dbg)
//   - helper to classify opcodes that need a memory operand cycle
package patp_pkg;

    // Opcodes
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INC   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // ALU operation selects
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_INC  = 2'b11;

    // Control FSM state encodings
    localparam logic [2:0] ST_FETCH_A = 3'd0;
    localparam logic [2:0] ST_FETCH_M = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXEC_M  = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    // Opcodes whose execution needs a data-memory access (opcodes 000..011)
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/patp_wait_timer.sv
// patp_wait_timer: counts cycles a memory request has been waiting.
//   clk, rst  : core clock, asynchronous active-high reset
//   clr       : clear the count (has priority over en)
//   en        : a wait cycle is in progress (request outstanding, no ack)
//   expired   : this wait cycle is the TIMEOUT_CYCLES-th one; never asserted
//               when TIMEOUT_CYCLES is 0 (timeout disabled)
module patp_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            // The count holds the number of wait cycles already elapsed, so
            // the limit is hit when the current wait cycle would make it
            // reach TIMEOUT_CYCLES.
            localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
            assign expired = en && (count_reg == LAST_WAIT);
        end
    endgenerate

endmodule

// File: rtl/patp_control.sv
// patp_control: fetch/decode/execute sequencer for the PATP accumulator core.
//   clk, rst   : core clock, asynchronous active-high reset
//   opcode     : IR opcode field (valid from the cycle after ir_load)
//   acc_zero   : accumulator equals zero
//   mem_ack    : memory completes the current read/write this cycle
//   ir_load    : IR load enable
//   pc_inc     : PC += 1
//   pc_load    : PC <= IR operand
//   mar_load   : MAR load enable
//   mar_sel    : MAR source, 0 = PC, 1 = IR operand
//   mem_rd     : memory read request
//   mem_wr     : memory write request (data = accumulator)
//   acc_load   : accumulator load enable
//   alu_op     : 00 PASS(mem), 01 ADD, 10 SUB, 11 INC
//   halted     : core stopped
//   fault      : stopped because a memory request timed out
//   state_dbg  : current state encoding
module patp_control
    import patp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       acc_zero,
    input  logic       mem_ack,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       mar_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       acc_load,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_dbg
);

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       fault_reg;
    logic       fault_set;

    logic       waiting;
    logic       timer_expired;

    logic       ir_load_c;
    logic       pc_inc_c;
    logic       pc_load_c;
    logic       mar_load_c;
    logic       mar_sel_c;
    logic       mem_rd_c;
    logic       mem_wr_c;
    logic       acc_load_c;
    logic [1:0] alu_op_c;

    // A wait cycle is any request cycle that does not complete.
    assign waiting = ((state_reg == ST_FETCH_M) || (state_reg == ST_EXEC_M)) && !mem_ack;

    patp_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_next != state_reg),
        .en      (waiting),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH_A;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fault_set) begin
                fault_reg <= 1'b1;
            end
        end
    end

    // Next state and raw (ungated) strobes. Memory-wait states test mem_ack
    // before the timer so a completing access always wins over the timeout.
    always_comb begin
        state_next = state_reg;
        fault_set  = 1'b0;
        ir_load_c  = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        mar_load_c = 1'b0;
        mar_sel_c  = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        acc_load_c = 1'b0;
        alu_op_c   = ALU_PASS;

        case (state_reg)
            ST_FETCH_A: begin
                mar_load_c = 1'b1;
                state_next = ST_FETCH_M;
            end

            ST_FETCH_M: begin
                mem_rd_c = 1'b1;
                if (mem_ack) begin
                    ir_load_c  = 1'b1;
                    pc_inc_c   = 1'b1;
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    fault_set  = 1'b1;
                    state_next = ST_HALT;
                end
            end

            ST_DECODE: begin
                if (is_mem_op(opcode)) begin
                    mar_sel_c  = 1'b1;
                    mar_load_c = 1'b1;
                    state_next = ST_EXEC_M;
                end else begin
                    case (opcode)
                        OP_INC: begin
                            acc_load_c = 1'b1;
                            alu_op_c   = ALU_INC;
                            state_next = ST_FETCH_A;
                        end
                        OP_JMP: begin
                            pc_load_c  = 1'b1;
                            state_next = ST_FETCH_A;
                        end
                        OP_JZ: begin
                            pc_load_c  = acc_zero;
                            state_next = ST_FETCH_A;
                        end
                        default: begin
                            state_next = ST_HALT;
                        end
                    endcase
                end
            end

            ST_EXEC_M: begin
                if (opcode == OP_STORE) begin
                    mem_wr_c = 1'b1;
                end else begin
                    mem_rd_c = 1'b1;
                end
                if (mem_ack) begin
                    if (opcode != OP_STORE) begin
                        acc_load_c = 1'b1;
                        case (opcode)
                            OP_ADD:  alu_op_c = ALU_ADD;
                            OP_SUB:  alu_op_c = ALU_SUB;
                            default: alu_op_c = ALU_PASS;
                        endcase
                    end
                    state_next = ST_FETCH_A;
                end else if (timer_expired) begin
                    fault_set  = 1'b1;
                    state_next = ST_HALT;
                end
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_FETCH_A;
            end
        endcase
    end

    // Reset gates every output combinationally so an in-flight memory request
    // is withdrawn the moment rst rises, not at the next clock edge.
    assign ir_load   = !rst && ir_load_c;
    assign pc_inc    = !rst && pc_inc_c;
    assign pc_load   = !rst && pc_load_c;
    assign mar_load  = !rst && mar_load_c;
    assign mar_sel   = !rst && mar_sel_c;
    assign mem_rd    = !rst && mem_rd_c;
    assign mem_wr    = !rst && mem_wr_c;
    assign acc_load  = !rst && acc_load_c;
    assign alu_op    = rst ? ALU_PASS : alu_op_c;
    assign halted    = !rst && (state_reg == ST_HALT);
    assign fault     = !rst && fault_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_patp_control.sv
// tb_patp_control: table-driven cycle-by-cycle check of patp_control.
// Each row gives the inputs for one cycle and the expected state/outputs.
// Inputs are driven on the falling edge, the expected record is pushed to a
// scoreboard queue, and the DUT response is popped and compared 1 ns later.
module tb_patp_control;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       acc_zero;
    logic       mem_ack;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       mar_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       halted;
    logic       fault;
    logic [2:0] state_dbg;

    patp_control #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .acc_zero  (acc_zero),
        .mem_ack   (mem_ack),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .mar_load  (mar_load),
        .mar_sel   (mar_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .acc_load  (acc_load),
        .alu_op    (alu_op),
        .halted    (halted),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Output bundle bit order:
    // [11] ir_load [10] pc_inc [9] pc_load [8] mar_load [7] mar_sel
    // [6] mem_rd [5] mem_wr [4] acc_load [3:2] alu_op [1] halted [0] fault
    localparam logic [11:0] O_NONE     = 12'h000;
    localparam logic [11:0] O_FA       = 12'h100; // mar_load, mar_sel=0
    localparam logic [11:0] O_RD       = 12'h040; // mem_rd only
    localparam logic [11:0] O_FM_ACK   = 12'hC40; // ir_load, pc_inc, mem_rd
    localparam logic [11:0] O_DEC_MEM  = 12'h180; // mar_load, mar_sel=1
    localparam logic [11:0] O_DEC_INC  = 12'h01C; // acc_load, alu=11
    localparam logic [11:0] O_PCLOAD   = 12'h200; // pc_load
    localparam logic [11:0] O_LOAD_ACK = 12'h050; // mem_rd, acc_load, alu=00
    localparam logic [11:0] O_ADD_ACK  = 12'h054; // mem_rd, acc_load, alu=01
    localparam logic [11:0] O_SUB_ACK  = 12'h058; // mem_rd, acc_load, alu=10
    localparam logic [11:0] O_WR       = 12'h020; // mem_wr only
    localparam logic [11:0] O_HALT     = 12'h002; // halted
    localparam logic [11:0] O_FAULT    = 12'h003; // halted, fault

    localparam logic [2:0] S_FA = 3'd0;
    localparam logic [2:0] S_FM = 3'd1;
    localparam logic [2:0] S_DE = 3'd2;
    localparam logic [2:0] S_EX = 3'd3;
    localparam logic [2:0] S_HT = 3'd4;

    typedef struct {
        logic        rst_v;
        logic [2:0]  op;
        logic        az;
        logic        ack;
        logic [2:0]  st;
        logic [11:0] o;
        int          id;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total;
    int   bad;

    function automatic logic [11:0] outs();
        return {ir_load, pc_inc, pc_load, mar_load, mar_sel, mem_rd, mem_wr,
                acc_load, alu_op, halted, fault};
    endfunction

    task automatic add(input logic r, input logic [2:0] op, input logic az,
                       input logic ack, input logic [2:0] st, input logic [11:0] o);
        vec_t v;
        v.rst_v = r;
        v.op    = op;
        v.az    = az;
        v.ack   = ack;
        v.st    = st;
        v.o     = o;
        v.id    = tbl.size();
        tbl.push_back(v);
    endtask

    task automatic check_one();
        vec_t e;
        logic [11:0] got;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard empty: actual=empty required=entry");
            return;
        end
        e   = exp_q.pop_front();
        got = outs();
        total++;
        if (state_dbg !== e.st) begin
            bad++;
            $display("FAIL row%0d state: actual=%0d required=%0d", e.id, state_dbg, e.st);
        end
        total++;
        if (got !== e.o) begin
            bad++;
            $display("FAIL row%0d outputs: actual=%h required=%h", e.id, got, e.o);
        end
        $display("row%0d rst=%0b op=%b az=%0b ack=%0b state=%0d outs=%h",
                 e.id, e.rst_v, e.op, e.az, e.ack, state_dbg, got);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst      = v.rst_v;
        opcode   = v.op;
        acc_zero = v.az;
        mem_ack  = v.ack;
        exp_q.push_back(v);
        #1;
        check_one();
    endtask

    // Full fetch + decode of a non-memory opcode with zero-wait memory.
    task automatic add_short(input logic [2:0] op, input logic az, input logic [11:0] dec_o);
        add(1'b0, op, az, 1'b1, S_FA, O_FA);
        add(1'b0, op, az, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, op, az, 1'b1, S_DE, dec_o);
    endtask

    initial begin
        vec_t v;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        opcode   = 3'b000;
        acc_zero = 1'b0;
        mem_ack  = 1'b0;

        // Reset held: everything quiet, state FETCH_A
        add(1'b1, 3'b000, 1'b0, 1'b1, S_FA, O_NONE);
        add(1'b1, 3'b100, 1'b1, 1'b1, S_FA, O_NONE);
        // INC twice, 3 cycles each
        add_short(3'b100, 1'b0, O_DEC_INC);
        add_short(3'b100, 1'b0, O_DEC_INC);
        // ADD with two wait cycles in EXEC_M: 6 cycles total
        add(1'b0, 3'b010, 1'b0, 1'b1, S_FA, O_FA);
        add(1'b0, 3'b010, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b010, 1'b0, 1'b0, S_DE, O_DEC_MEM);
        add(1'b0, 3'b010, 1'b0, 1'b0, S_EX, O_RD);
        add(1'b0, 3'b010, 1'b0, 1'b0, S_EX, O_RD);
        add(1'b0, 3'b010, 1'b0, 1'b1, S_EX, O_ADD_ACK);
        // LOAD and SUB, zero wait: 4 cycles each
        add(1'b0, 3'b000, 1'b0, 1'b1, S_FA, O_FA);
        add(1'b0, 3'b000, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b000, 1'b0, 1'b1, S_DE, O_DEC_MEM);
        add(1'b0, 3'b000, 1'b0, 1'b1, S_EX, O_LOAD_ACK);
        add(1'b0, 3'b011, 1'b0, 1'b1, S_FA, O_FA);
        add(1'b0, 3'b011, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b011, 1'b0, 1'b1, S_DE, O_DEC_MEM);
        add(1'b0, 3'b011, 1'b0, 1'b1, S_EX, O_SUB_ACK);
        // JZ not taken / taken, JMP
        add_short(3'b110, 1'b0, O_NONE);
        add_short(3'b110, 1'b1, O_PCLOAD);
        add_short(3'b101, 1'b0, O_PCLOAD);
        // STORE with one wait cycle
        add(1'b0, 3'b001, 1'b0, 1'b1, S_FA, O_FA);
        add(1'b0, 3'b001, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b001, 1'b0, 1'b0, S_DE, O_DEC_MEM);
        add(1'b0, 3'b001, 1'b0, 1'b0, S_EX, O_WR);
        add(1'b0, 3'b001, 1'b0, 1'b1, S_EX, O_WR);
        // Ack coincides with the 15th wait cycle of a fetch: ack wins
        add(1'b0, 3'b100, 1'b0, 1'b0, S_FA, O_FA);
        for (int i = 0; i < 14; i++) add(1'b0, 3'b100, 1'b0, 1'b0, S_FM, O_RD);
        add(1'b0, 3'b100, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b100, 1'b0, 1'b1, S_DE, O_DEC_INC);
        // HALT opcode: stops without fault, ack ignored afterwards
        add_short(3'b111, 1'b0, O_NONE);
        add(1'b0, 3'b111, 1'b0, 1'b1, S_HT, O_HALT);
        add(1'b0, 3'b111, 1'b0, 1'b1, S_HT, O_HALT);
        add(1'b1, 3'b111, 1'b0, 1'b0, S_FA, O_NONE);
        // Fetch timeout: 15 wait cycles, then HALT with fault latched
        add(1'b0, 3'b100, 1'b0, 1'b0, S_FA, O_FA);
        for (int i = 0; i < 15; i++) add(1'b0, 3'b100, 1'b0, 1'b0, S_FM, O_RD);
        add(1'b0, 3'b100, 1'b0, 1'b0, S_HT, O_FAULT);
        add(1'b0, 3'b100, 1'b0, 1'b1, S_HT, O_FAULT);
        add(1'b0, 3'b100, 1'b0, 1'b1, S_HT, O_FAULT);
        add(1'b1, 3'b100, 1'b0, 1'b1, S_FA, O_NONE);
        add(1'b0, 3'b000, 1'b0, 1'b1, S_FA, O_FA);

        foreach (tbl[i]) begin
            step(tbl[i]);
        end

        // Reset asserted in the middle of an EXEC_M read: the request must
        // vanish without waiting for a clock edge.
        add(1'b0, 3'b000, 1'b0, 1'b1, S_FM, O_FM_ACK);
        add(1'b0, 3'b000, 1'b0, 1'b0, S_DE, O_DEC_MEM);
        add(1'b0, 3'b000, 1'b0, 1'b0, S_EX, O_RD);
        for (int i = tbl.size() - 3; i < tbl.size(); i++) begin
            step(tbl[i]);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        v.rst_v = 1'b1; v.op = 3'b000; v.az = 1'b0; v.ack = 1'b0;
        v.st = S_FA; v.o = O_NONE; v.id = 1000;
        exp_q.push_back(v);
        #1;
        check_one();
        // First cycle after release is FETCH_A, then a fresh fetch read
        v.rst_v = 1'b0; v.st = S_FA; v.o = O_FA; v.id = 1001;
        step(v);
        v.st = S_FM; v.o = O_RD; v.id = 1002;
        step(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/patp_control.md
Name: patp_control

Overview:
- Control unit for the PATP accumulator core.
- Sequences fetch/decode/execute.
- Drives the instruction-register load strobe, PC increment/load, MAR load and source select, memory read/write requests with ack handshake, and accumulator/ALU control.
- Consumes the 3-bit opcode from the instruction register and the accumulator zero flag; sits beside the IR, PC, MAR, ALU and accumulator in the core top level.

Parameters:
- TIMEOUT_CYCLES, 15: cycles a memory request may wait for mem_ack before fault; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  3  IR opcode field (stable from cycle after ir_load)
- acc_zero  in  1  accumulator == 0
- mem_ack  in  1  memory completes current rd/wr this cycle
- ir_load  out  1  IR load enable
- pc_inc  out  1  PC += 1
- pc_load  out  1  PC <= IR operand
- mar_load  out  1  MAR load enable
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR operand
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request (data = accumulator)
- acc_load  out  1  accumulator load enable
- alu_op  out  2  00 PASS(mem), 01 ADD, 10 SUB, 11 INC
- halted  out  1  core stopped
- fault  out  1  stopped due to memory timeout
- state_dbg  out  3  current state encoding

Behaviour:
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INC, 101 JMP, 110 JZ, 111 HALT.
- States: FETCH_A, FETCH_M, DECODE, EXEC_M, HALT. Reset state FETCH_A.
- While rst is high, all outputs are 0 and state_dbg = FETCH_A encoding.
- Wait counter clears on reset and on every state change.
- FETCH_A: mar_sel=0, mar_load=1 -> FETCH_M.
- FETCH_M: mem_rd=1 held every cycle until mem_ack.
  - On the ack cycle (Mealy): ir_load=1, pc_inc=1 -> DECODE.
- DECODE (all strobes decided this cycle):
  - LOAD/STORE/ADD/SUB: mar_sel=1, mar_load=1 -> EXEC_M.
  - INC: acc_load=1, alu_op=11 -> FETCH_A.
  - JMP: pc_load=1 -> FETCH_A.
  - JZ: pc_load=acc_zero -> FETCH_A.
  - HALT -> HALT.
- EXEC_M: LOAD/ADD/SUB hold mem_rd=1; STORE holds mem_wr=1.
  - On the ack cycle: LOAD/ADD/SUB assert acc_load=1 with alu_op 00/01/10 respectively -> FETCH_A. STORE -> FETCH_A.
- mem_rd and mem_wr are never both 1; neither is asserted outside FETCH_M/EXEC_M.
- mem_ack in any other state is ignored.
- Timeout: counter increments each cycle in FETCH_M/EXEC_M without ack. When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with no ack -> HALT, fault=1.
- If ack and the timeout limit coincide, ack wins (normal transition).
- HALT: halted=1; all strobes 0. Only rst exits. fault stays latched until rst.
- Latency with zero-wait memory (ack in the same cycle as the request):
  - INC/JMP/JZ: 3 cycles per instruction.
  - LOAD/STORE/ADD/SUB: 4 cycles per instruction.
  - Each wait cycle adds 1.
- Reset mid-request: request is dropped immediately (async); fetch restarts at FETCH_A after release.
- pc_inc and pc_load are never both 1.

Decomposition:
- patp_pkg holds:
  - opcode constants (OP_LOAD..OP_HALT);
  - ALU op constants (ALU_PASS, ALU_ADD, ALU_SUB, ALU_INC);
  - state encoding constants (ST_FETCH_A=0, ST_FETCH_M=1, ST_DECODE=2, ST_EXEC_M=3, ST_HALT=4).
- One sub-module, patp_wait_timer: counter with clear/enable and an expired output parameterised by TIMEOUT_CYCLES. FSM and output decode stay in patp_control.

Test Plan:
- Reset, then zero-wait ack and opcode=100 (INC) -> FETCH_A, FETCH_M, DECODE repeating every 3 cycles. ir_load and pc_inc pulse one cycle each in FETCH_M; acc_load=1 with alu_op=11 in DECODE.
- opcode=010 (ADD), mem_ack delayed 2 cycles in EXEC_M -> mem_rd high 3 cycles, then acc_load=1 with alu_op=01 on the ack cycle. Instruction takes 6 cycles.
- opcode=110 with acc_zero=0 -> pc_load=0. Repeat with acc_zero=1 -> pc_load=1 in DECODE, pc_inc=0 that cycle.
- opcode=001 (STORE) -> mar_sel=1 and mar_load in DECODE; mem_wr=1 and mem_rd=0 in EXEC_M until ack.
- mem_ack held 0 in FETCH_M with TIMEOUT_CYCLES=15 -> after 15 wait cycles state=HALT, halted=1, fault=1. Ack then has no effect; rst clears both flags.
- opcode=111 -> HALT after DECODE, halted=1, fault=0. Assert rst mid-EXEC_M in a separate run -> mem_rd drops immediately; first cycle after release is FETCH_A with mar_load=1.
